edu_token_ctrl: RTL and testbench
=================================

Name: edu_token_ctrl

Overview:
- Sequential controller wrapped around the combinational per-row token-setup stage of the EDU fast-sliding datapath.
- On start, it latches a full patch of ESM-head bits, presents one row at a time on esmhead_row, and maintains the per-row flag mask on flag_out_row.
- It consumes the setup stage's token_exist_row_0 / token_col_row_0 and issues one (row, col) token per valid/ready handshake to the downstream token-passing logic.
- When every set bit in every row has been issued, it pulses done.

Parameters:
- NUM_UCROW, 4, unit cells per row; each row carries NUM_UCROW*2 bits.
- NUM_UCCOL, 4, number of rows in the patch.
- ROW_W, `log2(NUM_UCCOL)+1, width of the row index.
- COL_W, `log2(NUM_UCROW)+1, width of the column index; matches token_col_row_0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- esmhead_in  in  NUM_UCCOL*NUM_UCROW*2  patch ESM-head bits; row r occupies bits [r*2*NUM_UCROW +: 2*NUM_UCROW].
- esmhead_row  out  NUM_UCROW*2  selected row, to the setup stage.
- flag_out_row  out  NUM_UCROW*2  mask of already-issued bits in the selected row, to the setup stage.
- token_exist_row_0  in  1  from setup stage: an unflagged bit exists in the row.
- token_col_row_0  in  COL_W  from setup stage: lowest unflagged set index.
- token_valid  out  1  token offered.
- token_ready  in  1  downstream accepts.
- token_row  out  ROW_W  row of the offered token.
- token_col  out  COL_W  column of the offered token.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of the scan.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - esm_reg, row_idx, flag_reg, token_row, token_col all 0.
  - token_valid=0, done=0.
- Combinational outputs:
  - esmhead_row = esm_reg row row_idx when state is SCAN or ISSUE; 0 otherwise.
  - flag_out_row = flag_reg.
  - The setup stage is combinational, so its outputs are valid in the same cycle.
- IDLE:
  - start=1 latches esmhead_in into esm_reg; row_idx=0, flag_reg=0; next state SCAN.
- SCAN (one cycle per evaluation):
  - If token_exist_row_0=1: register token_row=row_idx and token_col=token_col_row_0, set token_valid=1, go to ISSUE.
  - Else if row_idx==NUM_UCCOL-1: go to DONE.
  - Else: row_idx+1, flag_reg=0, stay in SCAN.
- ISSUE:
  - token_valid is held, and token_row/token_col are stable, until token_ready=1.
  - On the valid&ready cycle: flag_reg[token_col]=1, token_valid=0 next cycle, go to SCAN on the same row.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy drops in the cycle after the done pulse.
- Latency:
  - An empty row costs 1 cycle.
  - Each token costs 1 SCAN cycle plus ≥1 ISSUE cycle.
  - Minimum per token is 2 cycles.
  - All-zero patch: start → done asserted NUM_UCCOL+1 cycles after the start edge.
- start outside IDLE is ignored; esm_reg is not reloaded.
- esmhead_in changes after the latch have no effect.
- Reset mid-ISSUE drops token_valid immediately (asynchronous) and discards all scan progress.
- token_ready while token_valid=0 is ignored.
- token_col_row_0 ≥ 2*NUM_UCROW never occurs; flag update uses only the low index bits.

Test Plan:
- Bench configuration for all scenarios: NUM_UCROW=4, NUM_UCCOL=3, token_ready=1 unless stated.
- Reset, then idle with no start → all outputs 0 and busy=0. Assert rst while in ISSUE → token_valid falls without waiting for a clk edge, state returns to IDLE.
- esmhead_in all zero, start at cycle 0 → three SCAN cycles; done=1 at cycle 4 only, no token_valid ever.
- Patch rows: row0=8'h00, row1=8'h85, row2=8'h02; start at cycle 0 → tokens (1,0), (1,2), (1,7), (2,1) in that order, then a single done pulse.
- Same patch, token_ready held low 5 cycles on the first token → token_valid, token_row=1 and token_col=0 stay stable all 5 cycles; flag_out_row stays 8'h00 until acceptance, then becomes 8'h01.
- start pulsed again while busy with a different esmhead_in → ignored; the issued token sequence is unchanged.
- Row 0 = 8'hFF → tokens (0,0) through (0,7) in ascending order; flag_out_row grows 01, 03, 07 … FF; the row then advances with flag_out_row cleared to 0.

Source files
------------

// File: rtl/edu_token_ctrl.sv
// Token-issue controller around the per-row token-setup stage: scans a latched ESM-head
// patch row by row and hands out one (row, col) token per valid/ready handshake.
module edu_token_ctrl #(
   parameter int NUM_UCROW = 4,
   parameter int NUM_UCCOL = 4,
   parameter int ROW_W     = $clog2(NUM_UCCOL) + 1,
   parameter int COL_W     = $clog2(NUM_UCROW) + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [NUM_UCCOL*NUM_UCROW*2-1:0] esmhead_in,
   output logic [NUM_UCROW*2-1:0]           esmhead_row,
   output logic [NUM_UCROW*2-1:0]           flag_out_row,
   input  logic                             token_exist_row_0,
   input  logic [COL_W-1:0]                 token_col_row_0,
   output logic                             token_valid,
   input  logic                             token_ready,
   output logic [ROW_W-1:0]                 token_row,
   output logic [COL_W-1:0]                 token_col,
   output logic                             busy,
   output logic                             done
);

   // state | meaning
   // IDLE  | waiting for start
   // SCAN  | one evaluation of the current row by the setup stage
   // ISSUE | token offered, waiting for token_ready
   // DONE  | one-cycle done pulse
   typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

   localparam int RW     = 2 * NUM_UCROW;
   localparam int FIDX_W = $clog2(RW);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_UCCOL - 1);

   state_t                             state;
   logic [NUM_UCCOL*NUM_UCROW*2-1:0]   esm_reg;
   logic [ROW_W-1:0]                   row_idx;
   logic [RW-1:0]                      flag_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         esm_reg     <= '0;
         row_idx     <= '0;
         flag_reg    <= '0;
         token_row   <= '0;
         token_col   <= '0;
         token_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  esm_reg  <= esmhead_in;
                  row_idx  <= '0;
                  flag_reg <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (token_exist_row_0) begin
                  token_row   <= row_idx;
                  token_col   <= token_col_row_0;
                  token_valid <= 1'b1;
                  state       <= ISSUE;
               end else if (row_idx == LAST_ROW) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  row_idx  <= row_idx + ROW_W'(1);
                  flag_reg <= '0;
               end
            end
            ISSUE: begin
               // mark the accepted bit so the setup stage moves on to the next one
               if (token_ready) begin
                  flag_reg[token_col[FIDX_W-1:0]] <= 1'b1;
                  token_valid <= 1'b0;
                  state       <= SCAN;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      esmhead_row = '0;
      if (state == SCAN || state == ISSUE) begin
         for (int r = 0; r < NUM_UCCOL; r++) begin
            if (row_idx == ROW_W'(r)) esmhead_row = esm_reg[r*RW +: RW];
         end
      end
   end

   assign flag_out_row = flag_reg;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_edu_token_ctrl.sv
// Bench for edu_token_ctrl: directed and random patches, token order checked against a
// list built from the patch bits, plus stall, restart and asynchronous reset cases.
module tb_edu_token_ctrl;
   localparam int NUM_UCROW = 4;
   localparam int NUM_UCCOL = 3;
   localparam int RW        = 2 * NUM_UCROW;
   localparam int ROW_W     = $clog2(NUM_UCCOL) + 1;
   localparam int COL_W     = $clog2(NUM_UCROW) + 1;
   localparam int PW        = NUM_UCCOL * RW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [PW-1:0]     esmhead_in = '0;
   logic [RW-1:0]     esmhead_row;
   logic [RW-1:0]     flag_out_row;
   logic              token_exist_row_0;
   logic [COL_W-1:0]  token_col_row_0;
   logic              token_valid;
   logic              token_ready = 1'b1;
   logic [ROW_W-1:0]  token_row;
   logic [COL_W-1:0]  token_col;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   edu_token_ctrl #(.NUM_UCROW(NUM_UCROW), .NUM_UCCOL(NUM_UCCOL)) dut (
      .clk(clk), .rst(rst), .start(start), .esmhead_in(esmhead_in),
      .esmhead_row(esmhead_row), .flag_out_row(flag_out_row),
      .token_exist_row_0(token_exist_row_0), .token_col_row_0(token_col_row_0),
      .token_valid(token_valid), .token_ready(token_ready),
      .token_row(token_row), .token_col(token_col), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // combinational setup stage: lowest set bit not yet flagged
   always_comb begin
      token_exist_row_0 = 1'b0;
      token_col_row_0   = '0;
      for (int i = RW - 1; i >= 0; i--) begin
         if (esmhead_row[i] && !flag_out_row[i]) begin
            token_exist_row_0 = 1'b1;
            token_col_row_0   = COL_W'(i);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // mode 0: ready always 1; 1: first token stalled 5 cycles; 2: start re-pulsed at cycle 3; 3: random ready
   task automatic run_scan(input logic [PW-1:0] patch, input int mode);
      int q[$];
      int ntok, stalls, cyc, stall_cnt, er, ec;
      bit done_seen, held, rdy;
      logic [ROW_W-1:0] hr;
      logic [COL_W-1:0] hc;
      logic [RW-1:0] prow, mask;
      for (int r = 0; r < NUM_UCCOL; r++)
         for (int c = 0; c < RW; c++)
            if (patch[r*RW + c]) q.push_back(r * 16 + c);
      ntok = q.size(); stalls = 0; stall_cnt = 0; done_seen = 0; held = 0;
      hr = '0; hc = '0;
      esmhead_in = patch; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 1;
      while (cyc < 300) begin
         if (mode == 2 && cyc == 3) begin esmhead_in = ~patch; start = 1'b1; end
         else start = 1'b0;
         if (done_seen) begin
            check("done_single", done, 0);
            check("busy_after_done", busy, 0);
            check("row_idle", esmhead_row, 0);
            break;
         end
         check("busy_run", busy, 1);
         if (held) begin
            check("valid_held", token_valid, 1);
            check("row_stable", token_row, hr);
            check("col_stable", token_col, hc);
         end
         rdy = (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (token_valid) begin
            if (q.size() == 0) check("extra_token", token_valid, 0);
            else begin
               er = q[0] / 16; ec = q[0] % 16;
               prow = patch[er*RW +: RW];
               mask = (RW'(1) << ec) - RW'(1);
               check("esmhead_row", esmhead_row, prow);
               check("flag_row", flag_out_row, prow & mask);
               check("tok_row", token_row, er);
               check("tok_col", token_col, ec);
               if (mode == 1 && q.size() == ntok && stall_cnt < 5) begin
                  rdy = 1'b0; stall_cnt++;
               end
               if (rdy) begin
                  void'(q.pop_front());
                  held = 0;
               end else begin
                  stalls++; held = 1; hr = token_row; hc = token_col;
               end
            end
         end
         if (done) begin
            done_seen = 1;
            check("done_cycle", cyc, NUM_UCCOL + 2 * ntok + stalls + 1);
            check("tokens_left", q.size(), 0);
         end
         token_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      token_ready = 1'b1;
      check("done_seen", done_seen, 1);
   endtask

   initial begin
      logic [PW-1:0] spec_patch, p;
      bit seen_valid;
      spec_patch = {8'h02, 8'h85, 8'h00};

      repeat (2) @(negedge clk);
      check("rst_valid", token_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_valid", token_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_row", esmhead_row, 0);
      check("idle_flag", flag_out_row, 0);
      check("idle_trow", token_row, 0);
      check("idle_tcol", token_col, 0);

      run_scan('0, 0);
      run_scan(spec_patch, 0);
      run_scan(spec_patch, 1);
      run_scan(spec_patch, 2);
      run_scan({8'h00, 8'h10, 8'hFF}, 0);
      run_scan(spec_patch, 3);
      for (int k = 0; k < 8; k++) begin
         p = PW'($urandom) & PW'($urandom);
         run_scan(p, 3);
      end

      // asynchronous reset while a token is waiting
      esmhead_in = {8'h00, 8'h00, 8'hFF}; start = 1'b1; token_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; seen_valid = 0;
      for (int i = 0; i < 10 && !seen_valid; i++) begin
         if (token_valid) seen_valid = 1;
         else @(negedge clk);
      end
      check("issue_reached", seen_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_valid", token_valid, 0);
      check("async_busy", busy, 0);
      check("async_flag", flag_out_row, 0);
      check("async_trow", token_row, 0);
      @(negedge clk);
      rst = 1'b0; token_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", token_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
